ml_sync_ctrl: RTL



---
 rtl/ml_sync_ctrl_pkg.sv | 13 +
 rtl/ml_sync_ctrl_lock_fsm.sv | 53 +++++
 rtl/ml_sync_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/ml_sync_ctrl_pkg.sv
// ml_sync_ctrl_pkg: shared types and defaults for the ML CP-correlation sync controller
package ml_sync_ctrl_pkg;
  localparam int N_MAX_DEF      = 2048;
  localparam int L_MAX_DEF      = 512;
  localparam int CNT_W_DEF      = 13;
  localparam int THETA_W_DEF    = 12;
  localparam int EPS_W_DEF      = 16;
  localparam int PIPE_DELAY_DEF = 12;
  typedef logic [CNT_W_DEF-1:0]   cnt_t;
  typedef logic [THETA_W_DEF-1:0] theta_t;
  typedef logic [EPS_W_DEF-1:0]   eps_t;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} sync_state_e;
endpackage

// File: rtl/ml_sync_ctrl_lock_fsm.sv
// sync_lock_fsm: declares timing lock when successive theta estimates agree modulo P
module sync_lock_fsm
  import ml_sync_ctrl_pkg::*;
#(
  parameter int THETA_W  = THETA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_strobe,
  input  logic [THETA_W-1:0] i_theta,
  input  logic [CNT_W-1:0]   i_p,
  output logic               o_locked
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(MISS_MAX + 1);
  sync_state_e r_state, w_next;
  logic [THETA_W-1:0] r_prev;
  logic [MW-1:0] r_match_cnt;
  logic [XW-1:0] r_miss_cnt;
  logic [CNT_W-1:0] w_d, w_dist;
  logic w_match;
  // circular distance: the shorter way round a period of P samples
  always_comb begin
    w_d = (i_theta > r_prev) ? CNT_W'(i_theta - r_prev) : CNT_W'(r_prev - i_theta);
    w_dist = (w_d < i_p - w_d) ? w_d : i_p - w_d;
    w_match = w_dist <= CNT_W'(TOL);
  end
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_state     <= SEARCH;
      r_prev      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else if (i_strobe) begin
      r_state     <= w_next;
      r_prev      <= i_theta;
      r_match_cnt <= (r_state == TRACK && w_next == TRACK && w_match) ? r_match_cnt + MW'(1) : '0;
      r_miss_cnt  <= (r_state == LOCKED && w_next == LOCKED && !w_match) ? r_miss_cnt + XW'(1) : '0;
    end
  always_comb begin
    w_next = r_state;
    if (i_strobe)
      w_next = (r_state == SEARCH) ? TRACK
             : (r_state == TRACK) ? ((w_match && r_match_cnt == MW'(LOCK_CNT - 1)) ? LOCKED : TRACK)
             : ((!w_match && r_miss_cnt == XW'(MISS_MAX - 1)) ? SEARCH : LOCKED);
  end
  always_comb o_locked = r_state == LOCKED;
endmodule

// File: rtl/ml_sync_ctrl.sv
// ml_sync_ctrl: sample counting, boundary strobe delay, theta/epsilon capture and lock tracking
module ml_sync_ctrl
  import ml_sync_ctrl_pkg::*;
#(
  parameter int N_MAX      = N_MAX_DEF,
  parameter int L_MAX      = L_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int THETA_W    = THETA_W_DEF,
  parameter int EPS_W      = EPS_W_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 3,
  parameter int MISS_MAX   = 2,
  localparam int LW        = $clog2(L_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         cfg_n_sel,
  input  logic [LW-1:0]      cfg_l,
  input  logic               cfg_load,
  input  logic [THETA_W-1:0] theta_in,
  input  logic [EPS_W-1:0]   eps_in,
  output logic [THETA_W-1:0] theta,
  output logic [EPS_W-1:0]   epsilon,
  output logic               out_valid,
  output logic               locked,
  output logic [CNT_W-1:0]   sym_period
);
  logic [CNT_W-1:0] r_n, r_l, r_cnt;
  logic [CNT_W-1:0] w_n, w_l, w_p;
  logic r_pulse;
  logic [PIPE_DELAY-1:0] r_pipe;
  logic w_s;
  always_comb begin
    w_n = CNT_W'(N_MAX) >> cfg_n_sel;
    w_l = (cfg_l == '0 || cfg_l > LW'(L_MAX)) ? CNT_W'(L_MAX) : CNT_W'(cfg_l);
    w_p = r_n + r_l;
    w_s = r_pipe[PIPE_DELAY-1];
  end
  assign sym_period = w_p;
  // first window spans 2N+L samples; each later window spans one symbol P
  always_ff @(posedge clk)
    if (rst) begin
      r_n       <= CNT_W'(N_MAX);
      r_l       <= CNT_W'(L_MAX);
      r_cnt     <= CNT_W'(2 * N_MAX + L_MAX - 1);
      r_pulse   <= 1'b0;
      r_pipe    <= '0;
      theta     <= '0;
      epsilon   <= '0;
      out_valid <= 1'b0;
    end else if (cfg_load) begin
      r_n       <= w_n;
      r_l       <= w_l;
      r_cnt     <= (w_n << 1) + w_l - CNT_W'(1);
      r_pulse   <= 1'b0;
      r_pipe    <= '0;
      out_valid <= 1'b0;
    end else begin
      r_pulse   <= in_valid && r_cnt == '0;
      r_pipe    <= {r_pipe[PIPE_DELAY-2:0], r_pulse};
      out_valid <= w_s;
      if (in_valid) r_cnt <= (r_cnt == '0) ? w_p - CNT_W'(1) : r_cnt - CNT_W'(1);
      if (w_s) begin
        theta   <= theta_in;
        epsilon <= eps_in;
      end
    end
  sync_lock_fsm #(
    .THETA_W (THETA_W),
    .CNT_W   (CNT_W),
    .TOL     (TOL),
    .LOCK_CNT(LOCK_CNT),
    .MISS_MAX(MISS_MAX)
  ) u_lock (
    .clk     (clk),
    .rst     (rst),
    .i_clear (cfg_load),
    .i_strobe(w_s && !cfg_load),
    .i_theta (theta_in),
    .i_p     (w_p),
    .o_locked(locked)
  );
endmodule
